loadarch_restore_seq: RTL and testbench
=======================================

Name: loadarch_restore_seq

Overview:
- Synthesizable arch-state restore sequencer. Feeds the tile's state-injection path: it consumes a 64-bit word stream carrying a loadarch snapshot and emits ordered register-write commands (PC/PRV, CSRs, CLINT time, XPRs, FPRs).
- Holds the core in reset until every write has drained and the checksum has passed, then releases it.
- Sits between the serial/TSI loader and the core's debug-write port; hardware replacement for force-based injection.

Parameters:
- FPR_EN, 1, include 32 FPR words in the stream (0 = omitted)
- RELEASE_DELAY, 16, cycles from write drain to core_reset_n rising (1..255)
- TIMEOUT_CYCLES, 0, max idle cycles between input words in LOAD/CHECK; 0 disables

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that arms a restore
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&in_ready
- in_data  in  64  snapshot word
- wr_valid  out  1  write command valid
- wr_ready  in  1  write command accepted
- wr_kind  out  2  0=CSR, 1=XPR, 2=FPR, 3=special
- wr_addr  out  12  CSR address / register index / special index
- wr_data  out  64  write value
- core_reset_n  out  1  core reset, low = held
- busy  out  1  in LOAD/CHECK/DRAIN/RELEASE
- done  out  1  restore complete, sticky until next start
- error  out  1  restore failed, sticky until next start
- error_code  out  2  1=checksum, 2=bad prv, 3=timeout
- words_accepted  out  7  data words accepted this restore

Behaviour:
- Reset values: in_ready=0, wr_valid=0, wr_kind/addr/data=0, core_reset_n=0, busy=0, done=0, error=0, error_code=0, words_accepted=0. State=IDLE.
- States: IDLE, LOAD, CHECK, DRAIN, RELEASE, DONE, ERROR.
- start in IDLE/DONE/ERROR: go to LOAD; clear idx, checksum accumulator, done, error, error_code and words_accepted; core_reset_n=0. start in any other state is ignored.
- Stream order by idx, giving {kind,addr}:
  - 0: {3,0} pc
  - 1: {3,1} prv
  - 2..20: CSR {0,addr}, in the order 0x003 fcsr, 0x105, 0x140, 0x141, 0x142, 0x143, 0x180, 0x300, 0x302, 0x303, 0x304, 0x305, 0x340, 0x341, 0x342, 0x343, 0x344, 0xB00, 0xB02
  - 21: {3,2} mtime
  - 22: {3,3} mtimecmp
  - 23..53: XPR {1,1..31}
  - 54..85: FPR {2,0..31}, only when FPR_EN=1
  - Data word count N = 86 (FPR_EN=1) or 54 (FPR_EN=0).
- LOAD:
  - in_ready = !wr_valid | wr_ready (single output register, 1-cycle latency).
  - On accept: register the write command, XOR the word into the accumulator, idx++, words_accepted++.
  - When idx reaches N after an accept, go to CHECK.
- prv check: idx=1 with in_data[1:0]==2 or in_data[63:2]!=0 → word is not forwarded, error_code=2, go to ERROR.
- CHECK: in_ready = 1. Accept one checksum word.
  - Equal to the accumulator → DRAIN.
  - Otherwise → ERROR, error_code=1.
- DRAIN: in_ready=0. Wait until wr_valid==0, then go to RELEASE with counter=RELEASE_DELAY.
- RELEASE: decrement each cycle. At 0: core_reset_n=1, done=1, go to DONE.
- DONE: in_ready=0; core_reset_n stays 1.
- ERROR:
  - error=1; in_ready=0; core_reset_n stays 0.
  - An already-held wr_valid persists until wr_ready; no new commands are issued.
- Timeout: in LOAD/CHECK, an idle counter resets on every accepted word. If it reaches TIMEOUT_CYCLES (nonzero) → ERROR, error_code=3.
- Write handshake: wr_* stay stable while wr_valid & !wr_ready.
- Simultaneous events: an accept and a timeout in the same cycle resolve as accept.
- Asynchronous reset mid-restore returns every output to its reset value immediately.

Test Plan:
- Nominal, FPR_EN=1, wr_ready=1: 86 words (pc=0x8000_0000, prv=3, others = idx) plus correct XOR checksum → 86 writes in order; word 2 gives {0,0x003}; word 23 gives {1,1}; word 85 gives {2,31}; core_reset_n rises exactly 16 cycles after the last write accepted; done=1.
- Backpressure: wr_ready toggles 1-in-3 → wr_* stable while stalled; in_ready low whenever wr_valid&!wr_ready; writes identical to nominal.
- Bad checksum: flip bit 0 of the checksum word → error=1, error_code=1, core_reset_n stays 0, done=0.
- prv=2 at word 1 → only the pc write is issued; error_code=2; words_accepted=1.
- TIMEOUT_CYCLES=8: stop in_valid after word 40 → error_code=3 on the 8th idle cycle. Then pulse start → flags clear and a full nominal restore succeeds.
- FPR_EN=0: 54 words plus checksum → no wr_kind=2 writes; done=1. Asserting reset low during RELEASE returns all outputs to their reset values.

Source files
------------

// File: rtl/loadarch_restore_seq.sv
// Arch-state restore sequencer: turns a loadarch snapshot word stream into ordered
// register-write commands and holds the core in reset until the writes drain and the checksum matches.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start, core held in reset
// S_LOAD    | accepting snapshot words, issuing one write per word
// S_CHECK   | waiting for the checksum word
// S_DRAIN   | checksum good, last write command still outstanding
// S_RELEASE | counting down the release delay
// S_DONE    | core released, restore complete
// S_ERROR   | checksum, prv or timeout failure; core stays in reset
module loadarch_restore_seq #(
   parameter int FPR_EN         = 1,
   parameter int RELEASE_DELAY  = 16,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [1:0]  wr_kind,
   output logic [11:0] wr_addr,
   output logic [63:0] wr_data,
   output logic        core_reset_n,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  error_code,
   output logic [6:0]  words_accepted
);

   localparam logic [6:0]  LAST_IDX = (FPR_EN != 0) ? 7'd85 : 7'd53;
   localparam logic [7:0]  REL_LOAD = 8'(RELEASE_DELAY);
   localparam logic [31:0] TO_LOAD  = 32'(TIMEOUT_CYCLES);
   localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_DRAIN, S_RELEASE, S_DONE, S_ERROR
   } state_t;

   state_t      state;
   logic [6:0]  idx;
   logic [63:0] acc;
   logic [31:0] idle_cnt;
   logic [7:0]  rel_cnt;
   logic        wr_free;
   logic        accept;
   logic        prv_bad;
   logic        timeout_hit;

   function automatic logic [13:0] slot_of(input logic [6:0] i);
      logic [6:0] r;
      r       = 7'd0;
      slot_of = 14'd0;
      case (i)
         7'd0:  slot_of = {2'd3, 12'h000};
         7'd1:  slot_of = {2'd3, 12'h001};
         7'd2:  slot_of = {2'd0, 12'h003};
         7'd3:  slot_of = {2'd0, 12'h105};
         7'd4:  slot_of = {2'd0, 12'h140};
         7'd5:  slot_of = {2'd0, 12'h141};
         7'd6:  slot_of = {2'd0, 12'h142};
         7'd7:  slot_of = {2'd0, 12'h143};
         7'd8:  slot_of = {2'd0, 12'h180};
         7'd9:  slot_of = {2'd0, 12'h300};
         7'd10: slot_of = {2'd0, 12'h302};
         7'd11: slot_of = {2'd0, 12'h303};
         7'd12: slot_of = {2'd0, 12'h304};
         7'd13: slot_of = {2'd0, 12'h305};
         7'd14: slot_of = {2'd0, 12'h340};
         7'd15: slot_of = {2'd0, 12'h341};
         7'd16: slot_of = {2'd0, 12'h342};
         7'd17: slot_of = {2'd0, 12'h343};
         7'd18: slot_of = {2'd0, 12'h344};
         7'd19: slot_of = {2'd0, 12'hB00};
         7'd20: slot_of = {2'd0, 12'hB02};
         7'd21: slot_of = {2'd3, 12'h002};
         7'd22: slot_of = {2'd3, 12'h003};
         default: begin
            if (i <= 7'd53) begin
               r       = i - 7'd22;
               slot_of = {2'd1, 5'd0, r};
            end else begin
               r       = i - 7'd54;
               slot_of = {2'd2, 5'd0, r};
            end
         end
      endcase
   endfunction

   // The single write-command register frees up in the same cycle it is accepted downstream.
   assign wr_free        = !wr_valid || wr_ready;
   assign in_ready       = (state == S_LOAD) ? wr_free : (state == S_CHECK);
   assign busy           = (state == S_LOAD) || (state == S_CHECK) ||
                           (state == S_DRAIN) || (state == S_RELEASE);
   assign accept         = in_valid && in_ready;
   assign prv_bad        = (in_data[1:0] == 2'd2) || (in_data[63:2] != 62'd0);
   assign timeout_hit    = TO_EN && !accept && (idle_cnt == 32'd1);
   assign words_accepted = idx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         idx          <= 7'd0;
         acc          <= 64'd0;
         idle_cnt     <= 32'd0;
         rel_cnt      <= 8'd0;
         wr_valid     <= 1'b0;
         wr_kind      <= 2'd0;
         wr_addr      <= 12'd0;
         wr_data      <= 64'd0;
         core_reset_n <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         error_code   <= 2'd0;
      end else begin
         if (wr_valid && wr_ready) wr_valid <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state        <= S_LOAD;
                  idx          <= 7'd0;
                  acc          <= 64'd0;
                  idle_cnt     <= TO_LOAD;
                  core_reset_n <= 1'b0;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  error_code   <= 2'd0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  idle_cnt <= TO_LOAD;
                  if (idx == 7'd1 && prv_bad) begin
                     error      <= 1'b1;
                     error_code <= 2'd2;
                     state      <= S_ERROR;
                  end else begin
                     wr_valid           <= 1'b1;
                     {wr_kind, wr_addr} <= slot_of(idx);
                     wr_data            <= in_data;
                     acc                <= acc ^ in_data;
                     idx                <= idx + 7'd1;
                     if (idx == LAST_IDX) state <= S_CHECK;
                  end
               end else if (timeout_hit) begin
                  error      <= 1'b1;
                  error_code <= 2'd3;
                  state      <= S_ERROR;
               end else if (idle_cnt != 32'd0) begin
                  idle_cnt <= idle_cnt - 32'd1;
               end
            end
            S_CHECK: begin
               if (accept) begin
                  if (in_data != acc) begin
                     error      <= 1'b1;
                     error_code <= 2'd1;
                     state      <= S_ERROR;
                  end else if (wr_free) begin
                     // Last write drains on this edge, so the release delay starts now.
                     state   <= S_RELEASE;
                     rel_cnt <= REL_LOAD;
                  end else begin
                     state <= S_DRAIN;
                  end
               end else if (timeout_hit) begin
                  error      <= 1'b1;
                  error_code <= 2'd3;
                  state      <= S_ERROR;
               end else if (idle_cnt != 32'd0) begin
                  idle_cnt <= idle_cnt - 32'd1;
               end
            end
            S_DRAIN: begin
               if (wr_free) begin
                  state   <= S_RELEASE;
                  rel_cnt <= REL_LOAD;
               end
            end
            S_RELEASE: begin
               if (rel_cnt <= 8'd1) begin
                  core_reset_n <= 1'b1;
                  done         <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  rel_cnt <= rel_cnt - 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_loadarch_restore_seq.sv
// Directed bench for loadarch_restore_seq: a stream-level model predicts the write sequence,
// word count and release/timeout timing, and a negedge monitor compares against the DUT.
module tb_loadarch_restore_seq;

   logic        clk = 1'b0;
   logic        rst_n, start, in_valid, wr_ready;
   logic [63:0] in_data;
   int          sel;

   logic        ir[2], wv[2], crn[2], bsy[2], dn[2], er[2];
   logic [1:0]  wk[2], ec[2];
   logic [11:0] wa[2];
   logic [63:0] wd[2];
   logic [6:0]  wcnt[2];
   logic        start0, start1, iv0, iv1;

   always #5 clk = ~clk;

   assign start0 = start && (sel == 0);
   assign start1 = start && (sel == 1);
   assign iv0    = in_valid && (sel == 0);
   assign iv1    = in_valid && (sel == 1);

   loadarch_restore_seq #(.FPR_EN(1), .RELEASE_DELAY(16), .TIMEOUT_CYCLES(8)) u0 (
      .clock(clk), .reset(rst_n), .start(start0), .in_valid(iv0), .in_ready(ir[0]),
      .in_data(in_data), .wr_valid(wv[0]), .wr_ready(wr_ready), .wr_kind(wk[0]),
      .wr_addr(wa[0]), .wr_data(wd[0]), .core_reset_n(crn[0]), .busy(bsy[0]),
      .done(dn[0]), .error(er[0]), .error_code(ec[0]), .words_accepted(wcnt[0]));

   loadarch_restore_seq #(.FPR_EN(0), .RELEASE_DELAY(16), .TIMEOUT_CYCLES(0)) u1 (
      .clock(clk), .reset(rst_n), .start(start1), .in_valid(iv1), .in_ready(ir[1]),
      .in_data(in_data), .wr_valid(wv[1]), .wr_ready(wr_ready), .wr_kind(wk[1]),
      .wr_addr(wa[1]), .wr_data(wd[1]), .core_reset_n(crn[1]), .busy(bsy[1]),
      .done(dn[1]), .error(er[1]), .error_code(ec[1]), .words_accepted(wcnt[1]));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Model: slot table, stimulus words and expected write queue
   logic [13:0] slot[0:85];
   logic [63:0] w[0:85];
   logic [63:0] last_ck;
   logic [77:0] expq[$];
   logic [77:0] obs[0:127];
   logic [77:0] cur, prev_cmd;
   int          m_n, m_idx, m_acc, n_obs, kind2_cnt;
   int          cyc, hs_cyc, acc_cyc, rise_cyc, err_cyc;
   bit          m_on, m_dead, prev_stall, prev_crn, prev_err, bp;

   initial begin
      int csr_list[19];
      csr_list = '{'h003, 'h105, 'h140, 'h141, 'h142, 'h143, 'h180, 'h300, 'h302, 'h303,
                   'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344, 'hB00, 'hB02};
      slot[0]  = {2'd3, 12'd0};
      slot[1]  = {2'd3, 12'd1};
      for (int i = 0; i < 19; i++) slot[2 + i] = {2'd0, 12'(csr_list[i])};
      slot[21] = {2'd3, 12'd2};
      slot[22] = {2'd3, 12'd3};
      for (int r = 1; r < 32; r++) slot[22 + r] = {2'd1, 12'(r)};
      for (int f = 0; f < 32; f++) slot[54 + f] = {2'd2, 12'(f)};
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         wr_ready = bp ? ((cyc % 3) == 0) : 1'b1;
      end
   end

   // Compare process: write order/content, handshake stability, counts and event timing
   initial begin
      m_on = 0;
      forever begin
         @(negedge clk);
         if (m_on) begin
            cur = {wk[sel], wa[sel], wd[sel]};
            if (prev_stall) begin
               chk("stall_valid", 128'(wv[sel]), 128'd1);
               chk("stall_cmd", 128'(cur), 128'(prev_cmd));
            end
            if (m_idx < m_n && !m_dead && wv[sel] && !wr_ready)
               chk("in_ready_bp", 128'(ir[sel]), 128'd0);
            chk("words_acc", 128'(wcnt[sel]), 128'(m_acc));
            if (wv[sel] && wr_ready) begin
               if (expq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_write: got %0h want none", cur);
               end else begin
                  chk("write", 128'(cur), 128'(expq.pop_front()));
               end
               if (n_obs < 128) obs[n_obs] = cur;
               n_obs++;
               if (wk[sel] == 2'd2) kind2_cnt++;
               hs_cyc = cyc + 1;
            end
            if (in_valid && ir[sel] && m_idx < m_n && !m_dead) begin
               if (m_idx == 1 && (in_data > 64'd3 || in_data == 64'd2)) m_dead = 1;
               else begin
                  m_acc++;
                  m_idx++;
               end
               acc_cyc = cyc + 1;
            end
            if (crn[sel] && !prev_crn) rise_cyc = cyc;
            if (er[sel] && !prev_err) err_cyc = cyc;
            prev_stall = wv[sel] && !wr_ready;
            prev_cmd   = cur;
            prev_crn   = crn[sel];
            prev_err   = er[sel];
         end
      end
   end

   task automatic send(input logic [63:0] d);
      bit ok;
      ok       = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (ir[sel]) begin
            ok = 1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL send_timeout: got in_ready=0 want 1 (data %0h)", d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int s, input bit bad_ck, input bit bad_prv, input int stop_after,
                      input bit bp_i);
      logic [63:0] ck;
      sel = s;
      bp  = bp_i;
      m_n = (s == 0) ? 86 : 54;
      ck  = 64'd0;
      for (int i = 0; i < m_n; i++) begin
         w[i] = (i == 0) ? 64'h8000_0000 : (i == 1) ? (bad_prv ? 64'd2 : 64'd3) : 64'(i);
         ck   = ck ^ w[i];
      end
      if (bad_ck) ck[0] = ~ck[0];
      last_ck = ck;
      expq.delete();
      for (int i = 0; i < m_n; i++) begin
         if (bad_prv && i > 0) break;
         if (stop_after >= 0 && i > stop_after) break;
         expq.push_back({slot[i], w[i]});
      end
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      m_idx = 0; m_acc = 0; m_dead = 0; prev_stall = 0; prev_crn = 0; prev_err = 0;
      n_obs = 0; kind2_cnt = 0; rise_cyc = -1; err_cyc = -1; hs_cyc = 0; acc_cyc = 0;
      m_on = 1;
      @(negedge clk);
      chk("start_done_clr", 128'(dn[sel]), 128'd0);
      chk("start_err_clr", 128'(er[sel]), 128'd0);
      chk("start_code_clr", 128'(ec[sel]), 128'd0);
      chk("start_crn_low", 128'(crn[sel]), 128'd0);
      chk("start_busy", 128'(bsy[sel]), 128'd1);
      @(posedge clk);
      #1;
      if (bad_prv) begin
         send(w[0]);
         send(w[1]);
      end else if (stop_after >= 0) begin
         for (int i = 0; i <= stop_after; i++) send(w[i]);
      end else begin
         for (int i = 0; i < m_n; i++) send(w[i]);
         send(ck);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_end();
      bit seen;
      seen = 0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (dn[sel] || er[sel]) begin
            seen = 1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL end_timeout: got done=0 error=0 want one set");
      end
      repeat (30) @(negedge clk);
      chk("queue_empty", 128'(expq.size()), 128'd0);
   endtask

   task automatic chk_success(input int n);
      wait_end();
      chk("done", 128'(dn[sel]), 128'd1);
      chk("error", 128'(er[sel]), 128'd0);
      chk("core_reset_n", 128'(crn[sel]), 128'd1);
      chk("busy_idle", 128'(bsy[sel]), 128'd0);
      chk("n_writes", 128'(n_obs), 128'(n));
      chk("release_delay", 128'(rise_cyc - hs_cyc), 128'd16);
      m_on = 0;
   endtask

   task automatic chk_fail(input int code, input int words, input int writes);
      wait_end();
      chk("err_flag", 128'(er[sel]), 128'd1);
      chk("err_code", 128'(ec[sel]), 128'(code));
      chk("err_done", 128'(dn[sel]), 128'd0);
      chk("err_crn", 128'(crn[sel]), 128'd0);
      chk("err_words", 128'(wcnt[sel]), 128'(words));
      chk("err_writes", 128'(n_obs), 128'(writes));
      m_on = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 64'd0; sel = 0; bp = 0;
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready", 128'(ir[d]), 128'd0);
         chk("rst_wr_valid", 128'(wv[d]), 128'd0);
         chk("rst_wr_cmd", 128'({wk[d], wa[d], wd[d]}), 128'd0);
         chk("rst_core_reset_n", 128'(crn[d]), 128'd0);
         chk("rst_busy", 128'(bsy[d]), 128'd0);
         chk("rst_done", 128'(dn[d]), 128'd0);
         chk("rst_error", 128'({er[d], ec[d]}), 128'd0);
         chk("rst_words", 128'(wcnt[d]), 128'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Nominal FPR_EN=1, plus literal pins on the model and the write ordering
      run(0, 0, 0, -1, 0);
      chk_success(86);
      chk("words_86", 128'(wcnt[0]), 128'd86);
      chk("pin_checksum", 128'(last_ck), 128'h8000_0003);
      chk("pin_pc", 128'(obs[0]), 128'({2'd3, 12'd0, 64'h8000_0000}));
      chk("pin_fcsr", 128'(obs[2][77:64]), 128'({2'd0, 12'h003}));
      chk("pin_x1", 128'(obs[23][77:64]), 128'({2'd1, 12'd1}));
      chk("pin_f31", 128'(obs[85][77:64]), 128'({2'd2, 12'd31}));

      // Backpressure on the write port
      run(0, 0, 0, -1, 1);
      chk_success(86);
      bp = 0;

      // Corrupted checksum
      run(0, 1, 0, -1, 0);
      chk_fail(1, 86, 86);

      // Illegal prv value
      run(0, 0, 1, -1, 0);
      chk_fail(2, 1, 1);

      // Stream stalls after word 40
      run(0, 0, 0, 40, 0);
      chk_fail(3, 41, 41);
      chk("timeout_cycle", 128'(err_cyc - acc_cyc), 128'd8);

      // Restart after the error
      run(0, 0, 0, -1, 0);
      chk_success(86);

      // FPR_EN=0
      run(1, 0, 0, -1, 0);
      chk_success(54);
      chk("words_54", 128'(wcnt[1]), 128'd54);
      chk("no_fpr_writes", 128'(kind2_cnt), 128'd0);
      chk("pin_checksum_54", 128'(last_ck), 128'h8000_0003);

      // Reset asserted during the release countdown
      run(1, 0, 0, -1, 0);
      repeat (6) @(negedge clk);
      chk("rel_busy", 128'(bsy[1]), 128'd1);
      chk("rel_crn_low", 128'(crn[1]), 128'd0);
      m_on  = 0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 128'(ir[1]), 128'd0);
      chk("mid_rst_wr_valid", 128'(wv[1]), 128'd0);
      chk("mid_rst_wr_cmd", 128'({wk[1], wa[1], wd[1]}), 128'd0);
      chk("mid_rst_crn", 128'(crn[1]), 128'd0);
      chk("mid_rst_busy", 128'(bsy[1]), 128'd0);
      chk("mid_rst_flags", 128'({dn[1], er[1], ec[1]}), 128'd0);
      chk("mid_rst_words", 128'(wcnt[1]), 128'd0);
      #20 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
